// File: rtl/remote_link_arbiter.sv
// Round-robin arbiter sharing one byte-serial remote link between two requesters.
// A grant covers an optional ID header byte, CMD_BYTES command bytes and RSP_BYTES response bytes.
module remote_link_arbiter #(
  parameter int unsigned CMD_BYTES = 8,
  parameter int unsigned RSP_BYTES = 8,
  parameter bit          HDR_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c0_req,
  output logic       c0_gnt,
  output logic       c0_full,
  input  logic       c0_wr_en,
  input  logic [7:0] c0_din,
  output logic       c0_empty,
  input  logic       c0_rd_en,
  output logic [7:0] c0_dout,
  input  logic       c1_req,
  output logic       c1_gnt,
  output logic       c1_full,
  input  logic       c1_wr_en,
  input  logic [7:0] c1_din,
  output logic       c1_empty,
  input  logic       c1_rd_en,
  output logic [7:0] c1_dout,
  input  logic       full,
  output logic       wr_en,
  output logic [7:0] din,
  input  logic       empty,
  output logic       rd_en,
  input  logic [7:0] dout
);

  localparam int unsigned MAXB = (CMD_BYTES > RSP_BYTES) ? CMD_BYTES : RSP_BYTES;
  localparam int unsigned CW   = $clog2(MAXB + 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_BYTES - 1);
  localparam logic [CW-1:0] RSP_LAST = CW'(RSP_BYTES - 1);

  typedef enum logic [1:0] {IDLE, HDR, CMD, RSP} state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [CW-1:0] cnt;
  logic          own_wr;
  logic          own_rd;
  logic [7:0]    own_din;

  always_comb begin
    own_wr  = owner ? c1_wr_en : c0_wr_en;
    own_rd  = owner ? c1_rd_en : c0_rd_en;
    own_din = owner ? c1_din   : c0_din;
    wr_en   = 1'b0;
    din     = '0;
    rd_en   = 1'b0;
    case (state)
      HDR: begin
        wr_en = ~full;
        din   = {7'b0, owner};
      end
      CMD: begin
        wr_en = own_wr & ~full;
        din   = own_din;
      end
      RSP: rd_en = own_rd & ~empty;
      default: ;
    endcase
  end

  assign c0_gnt   = (state != IDLE) & ~owner;
  assign c1_gnt   = (state != IDLE) &  owner;
  // Only the owner sees the real link flags; the other side is held off as full/empty.
  assign c0_full  = (state == CMD && !owner) ? full  : 1'b1;
  assign c1_full  = (state == CMD &&  owner) ? full  : 1'b1;
  assign c0_empty = (state == RSP && !owner) ? empty : 1'b1;
  assign c1_empty = (state == RSP &&  owner) ? empty : 1'b1;
  assign c0_dout  = dout;
  assign c1_dout  = dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            owner <= (c0_req && c1_req) ? ~last : c1_req;
            state <= HDR_EN ? HDR : CMD;
            cnt   <= '0;
          end
        end
        HDR: if (!full) state <= CMD;
        CMD: begin
          if (wr_en) begin
            if (cnt == CMD_LAST) begin
              cnt   <= '0;
              state <= RSP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RSP: begin
          if (rd_en) begin
            if (cnt == RSP_LAST) begin
              cnt   <= '0;
              last  <= owner;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_link_arbiter.sv
// Directed scoreboard bench for remote_link_arbiter: link command bytes and
// response bytes are queued when stimulus is set up and popped as the DUT moves them.
module tb_remote_link_arbiter;

  logic       clk;
  logic       rst_n;
  logic       c0_req, c0_wr_en, c0_rd_en;
  logic [7:0] c0_din;
  logic       c1_req, c1_wr_en, c1_rd_en;
  logic [7:0] c1_din;
  logic       c0_gnt, c0_full, c0_empty, c1_gnt, c1_full, c1_empty;
  logic [7:0] c0_dout, c1_dout;
  logic       link_full, link_empty, wr_en, rd_en;
  logic [7:0] din, link_dout;

  logic       nh_req, nh_wr, nh_rd;
  logic [7:0] nh_din;
  logic       nh_c0_gnt, nh_c0_full, nh_c0_empty, nh_c1_gnt, nh_c1_full, nh_c1_empty;
  logic [7:0] nh_c0_dout, nh_c1_dout, nh_link_din;
  logic       nh_link_wr, nh_link_rd;

  int total = 0;
  int bad   = 0;

  logic [7:0] base [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0] exp_link [$];
  logic [7:0] link_rsp [$];
  logic [7:0] exp_rsp  [$];
  logic [7:0] cmd_q    [$];
  int         rd_left = 0;
  bit         rd_pend = 0;
  bit         rd_who  = 0;
  int         link_wr_cnt = 0;
  int         link_rd_cnt = 0;

  remote_link_arbiter #(.CMD_BYTES(8), .RSP_BYTES(8), .HDR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_gnt(c0_gnt), .c0_full(c0_full), .c0_wr_en(c0_wr_en), .c0_din(c0_din),
    .c0_empty(c0_empty), .c0_rd_en(c0_rd_en), .c0_dout(c0_dout),
    .c1_req(c1_req), .c1_gnt(c1_gnt), .c1_full(c1_full), .c1_wr_en(c1_wr_en), .c1_din(c1_din),
    .c1_empty(c1_empty), .c1_rd_en(c1_rd_en), .c1_dout(c1_dout),
    .full(link_full), .wr_en(wr_en), .din(din), .empty(link_empty), .rd_en(rd_en), .dout(link_dout)
  );

  remote_link_arbiter #(.CMD_BYTES(8), .RSP_BYTES(8), .HDR_EN(1'b0)) dut_nh (
    .clk(clk), .rst_n(rst_n),
    .c0_req(1'b0), .c0_gnt(nh_c0_gnt), .c0_full(nh_c0_full), .c0_wr_en(1'b0), .c0_din(8'h00),
    .c0_empty(nh_c0_empty), .c0_rd_en(1'b0), .c0_dout(nh_c0_dout),
    .c1_req(nh_req), .c1_gnt(nh_c1_gnt), .c1_full(nh_c1_full), .c1_wr_en(nh_wr), .c1_din(nh_din),
    .c1_empty(nh_c1_empty), .c1_rd_en(nh_rd), .c1_dout(nh_c1_dout),
    .full(link_full), .wr_en(nh_link_wr), .din(nh_link_din), .empty(link_empty), .rd_en(nh_link_rd),
    .dout(link_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    c0_wr_en = c0_gnt && cmd_q.size() > 0;
    c1_wr_en = c1_gnt && cmd_q.size() > 0;
    c0_din   = (cmd_q.size() > 0) ? cmd_q[0] : 8'h00;
    c1_din   = (cmd_q.size() > 0) ? cmd_q[0] : 8'h00;
    c0_rd_en = c0_gnt && cmd_q.size() == 0 && rd_left > 0;
    c1_rd_en = c1_gnt && cmd_q.size() == 0 && rd_left > 0;
  endtask

  task automatic step();
    logic [7:0] nd;
    logic [7:0] e;
    bit did_rd, acc_wr, acc_rd, own;
    @(negedge clk);
    nd = 8'h00;
    did_rd = 1'b0;
    own = c1_gnt;
    if (c0_gnt) begin
      chk("iso_c1_full", c1_full, 1);
      chk("iso_c1_empty", c1_empty, 1);
    end
    if (c1_gnt) begin
      chk("iso_c0_full", c0_full, 1);
      chk("iso_c0_empty", c0_empty, 1);
    end
    if (link_full)  chk("wr_while_full", wr_en, 0);
    if (link_empty) chk("rd_while_empty", rd_en, 0);
    if (rd_pend) begin
      e = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 8'hxx;
      chk("rsp_byte", rd_who ? c1_dout : c0_dout, e);
    end
    if (wr_en) begin
      link_wr_cnt++;
      if (exp_link.size() == 0) chk("link_unexpected_wr", wr_en, 0);
      else chk("link_din", din, exp_link.pop_front());
    end
    if (rd_en) begin
      link_rd_cnt++;
      did_rd = 1'b1;
      nd = (link_rsp.size() > 0) ? link_rsp.pop_front() : 8'h00;
    end
    acc_wr = own ? (c1_gnt & c1_wr_en & ~c1_full) : (c0_gnt & c0_wr_en & ~c0_full);
    acc_rd = own ? (c1_gnt & c1_rd_en & ~c1_empty) : (c0_gnt & c0_rd_en & ~c0_empty);
    @(posedge clk);
    #1;
    if (did_rd) link_dout = nd;
    rd_pend = did_rd;
    rd_who  = own;
    if (acc_wr) void'(cmd_q.pop_front());
    if (acc_rd) rd_left--;
    drive();
  endtask

  task automatic chk_reset();
    chk("rst_c0_gnt", c0_gnt, 0);
    chk("rst_c1_gnt", c1_gnt, 0);
    chk("rst_c0_full", c0_full, 1);
    chk("rst_c1_full", c1_full, 1);
    chk("rst_c0_empty", c0_empty, 1);
    chk("rst_c1_empty", c1_empty, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_din", din, 0);
  endtask

  task automatic txn(input bit id, input bit r0, input bit r1, input bit keep,
                     input bit fstall, input bit estall, input bit abort);
    int fs, es;
    bit seen, done;
    fs = 0; es = 0; seen = 0; done = 0;
    link_wr_cnt = 0;
    link_rd_cnt = 0;
    exp_link.push_back({7'b0, id});
    for (int i = 0; i < 8; i++) begin
      cmd_q.push_back(base[i] ^ (id ? 8'h5A : 8'h00));
      exp_link.push_back(base[i] ^ (id ? 8'h5A : 8'h00));
      link_rsp.push_back(base[7-i] ^ (id ? 8'hA5 : 8'h00));
      exp_rsp.push_back(base[7-i] ^ (id ? 8'hA5 : 8'h00));
    end
    rd_left = 8;
    c0_req = r0;
    c1_req = r1;
    drive();
    if (!(c0_gnt || c1_gnt)) begin
      chk("gnt_before_sample", id ? c1_gnt : c0_gnt, 0);
      step();
      chk("gnt_latency", id ? c1_gnt : c0_gnt, 1);
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      if (fstall && fs < 3 && link_wr_cnt == 5) begin link_full = 1'b1; fs++; end
      else link_full = 1'b0;
      if (estall && es < 5 && link_rd_cnt == 3) begin link_empty = 1'b1; es++; end
      else link_empty = 1'b0;
      if (id ? c1_gnt : c0_gnt) seen = 1'b1;
      chk("other_gnt", id ? c0_gnt : c1_gnt, 0);
      if (abort && link_wr_cnt == 5) begin done = 1'b1; break; end
      if (seen && rd_left == 0) begin
        chk("gnt_drop_after_last_rd", id ? c1_gnt : c0_gnt, 0);
        done = 1'b1;
        break;
      end
    end
    chk("txn_done", done, 1);
    if (abort) return;
    if (!keep) begin
      c0_req = 1'b0;
      c1_req = 1'b0;
    end
    step();
    chk("link_wr_total", link_wr_cnt, 9);
    chk("link_rd_total", link_rd_cnt, 8);
    chk("link_bytes_left", exp_link.size(), 0);
    chk("rsp_bytes_left", exp_rsp.size(), 0);
  endtask

  initial begin
    bit nh_seen;
    rst_n = 1'b0;
    c0_req = 0; c0_wr_en = 0; c0_rd_en = 0; c0_din = 8'h00;
    c1_req = 0; c1_wr_en = 0; c1_rd_en = 0; c1_din = 8'h00;
    nh_req = 0; nh_wr = 0; nh_rd = 0; nh_din = 8'h00;
    link_full = 0; link_empty = 0; link_dout = 8'h00;
    #3;
    chk_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // both requesters: c0 wins the first tie, then c1 with header 01
    txn(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // single requester, no stalls
    txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // command backpressure, then response stall
    txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // headerless instance: first link byte is the requester's own
    nh_req = 1'b1;
    nh_wr  = 1'b1;
    nh_din = 8'h5A;
    nh_seen = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (nh_link_wr) begin
        chk("nh_first_byte", nh_link_din, 8'h5A);
        chk("nh_c1_gnt", nh_c1_gnt, 1);
        chk("nh_c0_gnt", nh_c0_gnt, 0);
        nh_seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("nh_wr_seen", nh_seen, 1);
    @(posedge clk);
    #1;
    nh_req = 1'b0;
    nh_wr  = 1'b0;

    // reset in the middle of the command phase
    txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    c0_req = 1'b0;
    rst_n  = 1'b0;
    #2;
    chk_reset();
    cmd_q.delete();
    exp_link.delete();
    link_rsp.delete();
    exp_rsp.delete();
    rd_left = 0;
    rd_pend = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
